// File: rtl/spi_shifter_pkg.sv
// rtl/spi_shifter_pkg.sv - shared constants and helpers for the SPI byte engine
//
// Holds the FSM state encoding, the bits-per-transfer and divider-width
// constants, and the run-time half-period clamp used when the
// SPI_SHIFTER_RTDIV_EN build option is enabled.

package spi_shifter_pkg;

    // FSM state encoding; 2'd3 is unused and recovers to ST_IDLE.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    localparam int SPI_BITS = 8;
    localparam int DIV_W    = 4;

    // A half-period of zero cycles is meaningless, so treat it as one.
    function automatic logic [DIV_W-1:0] eff_half(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// rtl/spi_clkdiv.sv - SCK half-period counter emitting a one-cycle tick
//
// Ports:
//   CLK     in   block clock
//   RST     in   asynchronous active-high reset
//   restart in   clears the count (driven on transfer accept)
//   enable  in   count only while a transfer is running
//   half    in   half-period length in CLK cycles (1..15)
//   tick    out  high on the last cycle of each half-period

module spi_clkdiv
    import spi_shifter_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             restart,
    input  logic             enable,
    input  logic [DIV_W-1:0] half,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = enable && !restart && (cnt == half - DIV_W'(1));

    // The count returns to zero on every tick so each SCK phase
    // lasts exactly 'half' cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (restart || !enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_shifter.sv
// rtl/spi_shifter.sv - SPI mode 0, MSB-first byte engine
//
// Shifts TXD out on SCK/MOSI while capturing MISO, then presents the
// received byte on RXD with a one-cycle DONE pulse.
//
// Ports:
//   CLK   in   block clock
//   RST   in   asynchronous active-high reset
//   START in   single-cycle request, honoured only while BUSY=0
//   TXD   in   8-bit byte to send, sampled on accept
//   MISO  in   serial data from the device
//   DIV   in   4-bit run-time half-period (only with SPI_SHIFTER_RTDIV_EN)
//   SCK   out  SPI clock, idle low
//   MOSI  out  serial data to the device
//   RXD   out  last completed received byte
//   BUSY  out  transfer in progress
//   DONE  out  one-cycle completion pulse
//
// Build option: SPI_SHIFTER_RTDIV_EN adds the DIV port; otherwise the
// half-period is the DIVIDE parameter.

module spi_shifter
    import spi_shifter_pkg::*;
#(
    parameter int         DIVIDE    = 2,
    parameter logic [7:0] RESET_RXD = 8'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] TXD,
    input  logic       MISO,
`ifdef SPI_SHIFTER_RTDIV_EN
    input  logic [3:0] DIV,
`endif
    output logic       SCK,
    output logic       MOSI,
    output logic [7:0] RXD,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [DIV_W-1:0] HALF_P = DIVIDE[DIV_W-1:0];

    logic [1:0]       state;
    logic [7:0]       shreg;
    logic [2:0]       bitcnt;
    logic [DIV_W-1:0] half;
    logic             accept;
    logic             running;
    logic             tick;

    assign accept  = (state == ST_IDLE) && START;
    assign running = (state == ST_LOW) || (state == ST_HIGH);

`ifdef SPI_SHIFTER_RTDIV_EN
    // DIV is frozen at accept so mid-transfer changes cannot stretch SCK.
    logic [DIV_W-1:0] half_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            half_q <= eff_half(HALF_P);
        end else if (accept) begin
            half_q <= eff_half(DIV);
        end
    end

    assign half = half_q;
`else
    assign half = HALF_P;
`endif

    spi_clkdiv u_clkdiv (
        .CLK     (CLK),
        .RST     (RST),
        .restart (accept),
        .enable  (running),
        .half    (half),
        .tick    (tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            SCK    <= 1'b0;
            MOSI   <= 1'b0;
            RXD    <= RESET_RXD;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            shreg  <= 8'h00;
            bitcnt <= 3'd0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        shreg  <= TXD;
                        MOSI   <= TXD[7];
                        BUSY   <= 1'b1;
                        bitcnt <= 3'd0;
                        state  <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    // Rising SCK: capture MISO into the vacated LSB.
                    if (tick) begin
                        SCK   <= 1'b1;
                        shreg <= {shreg[6:0], MISO};
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // Falling SCK: either finish or present the next bit,
                    // which the rising-edge shift has already moved to bit 7.
                    if (tick) begin
                        SCK    <= 1'b0;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'(SPI_BITS - 1)) begin
                            RXD   <= shreg;
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            MOSI  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            MOSI  <= shreg[7];
                            state <= ST_LOW;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    SCK   <= 1'b0;
                    MOSI  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shifter.sv
// tb/tb_spi_shifter.sv - self-checking bench for spi_shifter

module tb_spi_shifter;

    localparam int D_PARAM = 2;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic       START = 1'b0;
    logic [7:0] TXD   = 8'h00;
    logic       MISO;
    logic       SCK, MOSI, BUSY, DONE;
    logic [7:0] RXD;
`ifdef SPI_SHIFTER_RTDIV_EN
    logic [3:0] DIV = 4'd2;
`endif

    int checks = 0;
    int errors = 0;

    // Model: m_k counts cycles since accept (1..16d busy, 16d+1 done, 0 idle).
    logic [7:0] dev   = 8'h00;
    logic [7:0] m_dev = 8'h00;
    logic [7:0] m_tx  = 8'h00;
    logic [7:0] m_rxd = 8'h00;
    int         m_k   = 0;
    int         m_d   = D_PARAM;
    int         nk;
    logic       m_busy;

    always #5 CLK = ~CLK;

    spi_shifter #(.DIVIDE(D_PARAM), .RESET_RXD(8'h00)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .TXD   (TXD),
        .MISO  (MISO),
`ifdef SPI_SHIFTER_RTDIV_EN
        .DIV   (DIV),
`endif
        .SCK   (SCK),
        .MOSI  (MOSI),
        .RXD   (RXD),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic f_busy(input int k, input int d);
        return (k >= 1) && (k <= 16 * d);
    endfunction

    // Phase index: even = SCK low half, odd = SCK high half; bit = phase/2.
    function automatic int f_ph(input int k, input int d);
        return f_busy(k, d) ? (k - 1) / d : 0;
    endfunction

    function automatic logic f_sck(input int k, input int d);
        return f_busy(k, d) && (f_ph(k, d) % 2 == 1);
    endfunction

    function automatic logic f_bit(input int k, input int d, input logic [7:0] b);
        if (!f_busy(k, d)) return 1'b0;
        return b[7 - f_ph(k, d) / 2];
    endfunction

    always_comb m_busy = f_busy(m_k, m_d);
    always_comb nk     = m_busy ? m_k + 1 : (START ? 1 : 0);
    // Device presents bit b for the whole of SPI bit slot b.
    always_comb MISO   = f_bit(m_k, m_d, m_dev);

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_k   <= 0;
            m_rxd <= 8'h00;
        end else begin
            if (!m_busy && START) begin
                m_tx  <= TXD;
                m_dev <= dev;
`ifdef SPI_SHIFTER_RTDIV_EN
                m_d   <= (DIV == 4'd0) ? 1 : int'(DIV);
`endif
            end
            if (m_busy && nk == 16 * m_d + 1) m_rxd <= m_dev;
            m_k <= nk;
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            chk("sck",  32'(SCK),  32'(f_sck(m_k, m_d)));
            chk("mosi", 32'(MOSI), 32'(f_bit(m_k, m_d, m_tx)));
            chk("busy", 32'(BUSY), 32'(m_busy));
            chk("done", 32'(DONE), 32'(m_k == 16 * m_d + 1));
            chk("rxd",  32'(RXD),  32'(m_rxd));
        end
    end

    task automatic xfer(input logic [7:0] tx, input logic [7:0] dv);
        @(posedge CLK); #2;
        TXD = tx; dev = dv; START = 1'b1;
        @(posedge CLK); #2;
        START = 1'b0; TXD = ~tx;
    endtask

    initial begin
        int busy_n, rises, done_at, dones;
        logic prev;
        logic [7:0] cap;

        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("rst_sck",  32'(SCK),  32'd0);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_rxd",  32'(RXD),  32'h00);
        repeat (50) @(posedge CLK);

        // Basic transfer: A5 out, 3C in.
        xfer(8'hA5, 8'h3C);
        busy_n = 0; done_at = 0; cap = 8'h00; prev = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (BUSY) busy_n++;
            if (SCK && !prev) cap = {cap[6:0], MOSI};
            prev = SCK;
            if (DONE && done_at == 0) done_at = i;
        end
        chk("a5_busy_cycles", 32'(busy_n), 32'd32);
        chk("a5_mosi_byte",   32'(cap),    32'hA5);
        chk("a5_done_lat",    32'(done_at), 32'd33);
        chk("a5_rxd",         32'(RXD),    32'h3C);

        // START pulses mid-transfer must be ignored.
        xfer(8'h6B, 8'h96);
        dones = 0;
        for (int i = 2; i <= 40; i++) begin
            @(posedge CLK); #2;
            START = (i == 5) || (i == 20);
            @(negedge CLK);
            if (DONE) dones++;
        end
        START = 1'b0;
        chk("ign_dones", 32'(dones), 32'd1);
        chk("ign_rxd",   32'(RXD),   32'h96);

        // Back-to-back: START accepted in the DONE cycle.
        xfer(8'h81, 8'h3C);
        repeat (32) @(posedge CLK);
        #2;
        chk("b2b_done1", 32'(DONE), 32'd1);
        chk("b2b_gap",   32'(SCK),  32'd0);
        TXD = 8'hFF; dev = 8'hFF; START = 1'b1;
        @(posedge CLK); #2;
        START = 1'b0;
        chk("b2b_busy2", 32'(BUSY), 32'd1);
        chk("b2b_rxd_hold_a", 32'(RXD), 32'h3C);
        repeat (16) @(posedge CLK);
        #2;
        chk("b2b_rxd_hold_b", 32'(RXD), 32'h3C);
        repeat (16) @(posedge CLK);
        #2;
        chk("b2b_done2", 32'(DONE), 32'd1);
        chk("b2b_rxd2",  32'(RXD),  32'hFF);

        // Reset mid-transfer after the 4th SCK rise.
        xfer(8'h5A, 8'h00);
        repeat (40) @(posedge CLK);
        chk("pre_rst_rxd", 32'(RXD), 32'h00);
        xfer(8'hA5, 8'hFF);
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 100 && rises < 4; i++) begin
            @(negedge CLK);
            if (SCK && !prev) rises++;
            prev = SCK;
        end
        chk("rst_reach_rise4", 32'(rises), 32'd4);
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        chk("abort_sck",  32'(SCK),  32'd0);
        chk("abort_mosi", 32'(MOSI), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_rxd",  32'(RXD),  32'h00);
        @(posedge CLK); #2;
        RST = 1'b0;
        xfer(8'hC3, 8'h5A);
        repeat (40) @(posedge CLK);
        chk("post_rst_rxd", 32'(RXD), 32'h5A);

`ifdef SPI_SHIFTER_RTDIV_EN
        DIV = 4'd0;
        xfer(8'h12, 8'h34);
        DIV = 4'd7;
        repeat (16) @(posedge CLK);
        #2;
        chk("div0_done17", 32'(DONE), 32'd1);
        DIV = 4'd3;
        xfer(8'h9C, 8'hE1);
        DIV = 4'd9;
        repeat (48) @(posedge CLK);
        #2;
        chk("div3_done49", 32'(DONE), 32'd1);
        chk("div3_rxd",    32'(RXD),  32'hE1);
        repeat (4) @(posedge CLK);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
